// File: rtl/hnf_rxreq_mc.sv
// hnf_rxreq_mc: multi-channel CHI RXREQ ingress for the HN-F.
// Each of NUM_CH links has its own L-credit counter and flit FIFO.
// The links are merged by a round-robin arbiter onto one valid/ready
// port towards POCQ allocation. The arbiter keeps its grant while the
// offered flit is stalled.
// Optional feature macro: HNF_RXREQ_LCRD_RETURN_EN. When it is defined,
// a credited flit with opcode 7'h00 (ReqLCrdReturn) only hands its
// credit back and is not buffered.
module hnf_rxreq_mc #(
  parameter int NUM_CH     = 2,
  parameter int FLIT_W     = 128,
  parameter int DEPTH      = 8,
  parameter int CRD_MAX    = 4,
  parameter int OPCODE_LSB = 25
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic [NUM_CH*FLIT_W-1:0]                        rxreqflit,
  input  logic [NUM_CH-1:0]                               rxreqflitv,
  input  logic [NUM_CH-1:0]                               rxreqflitpend,
  output logic [NUM_CH-1:0]                               rxreqlcrdv,
  output logic                                            pocq_req_valid,
  output logic [FLIT_W-1:0]                               pocq_req_flit,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  pocq_req_ch,
  input  logic                                            pocq_req_ready,
  output logic [NUM_CH-1:0]                               rxreq_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W:0]   DEPTH_V   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CRD_MAX_V = CNT_W'(CRD_MAX);
  localparam logic [CH_W:0]    NUM_CH_V  = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

  logic [CNT_W-1:0]  crd_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  crd_n  [NUM_CH];
  logic [CNT_W-1:0]  cnt_n  [NUM_CH];
  logic [PTR_W-1:0]  wptr_q [NUM_CH];
  logic [PTR_W-1:0]  rptr_q [NUM_CH];
  logic [FLIT_W-1:0] mem_q  [NUM_CH][DEPTH];

  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] write;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] nonempty;

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   lock_ch;
  logic              lock_v;
  logic [CH_W-1:0]   win;
  logic              found;
  logic [CH_W:0]     cand;
  logic              handshake;

  // The pending hint carries no information this block needs.
  logic unused_pend;
  assign unused_pend = ^rxreqflitpend;

  // Per-channel occupancy flags feed the arbiter and the output valid.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
    end
  end

  assign pocq_req_valid = |nonempty;
  assign handshake      = pocq_req_valid && pocq_req_ready;

  // Round-robin pick from rr_ptr upwards, or the held grant while stalled.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (lock_v) begin
      win   = lock_ch;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = {1'b0, rr_ptr} + (CH_W + 1)'(k);
        if (cand >= NUM_CH_V) begin
          cand = cand - NUM_CH_V;
        end
        if (!found && nonempty[cand[CH_W-1:0]]) begin
          win   = cand[CH_W-1:0];
          found = 1'b1;
        end
      end
    end
  end

  // Present the head of the winning FIFO, zeros when nothing is offered.
  always_comb begin
    pocq_req_flit = '0;
    pocq_req_ch   = '0;
    if (pocq_req_valid) begin
      pocq_req_flit = mem_q[win][rptr_q[win]];
      pocq_req_ch   = win;
    end
  end

  // Next credit/occupancy values with net arithmetic, plus the grant decision.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = rxreqflitv[i] && (crd_q[i] != '0);
      drop[i]   = rxreqflitv[i] && (crd_q[i] == '0);
`ifdef HNF_RXREQ_LCRD_RETURN_EN
      write[i]  = accept[i] && (rxreqflit[i*FLIT_W + OPCODE_LSB +: 7] != 7'h00);
`else
      write[i]  = accept[i];
`endif
      pop[i]    = handshake && (win == CH_W'(i));
      crd_n[i]  = crd_q[i] - CNT_W'(accept[i]);
      cnt_n[i]  = cnt_q[i] + CNT_W'(write[i]) - CNT_W'(pop[i]);
      grant[i]  = (crd_n[i] < CRD_MAX_V) &&
                  (({1'b0, crd_n[i]} + {1'b0, cnt_n[i]}) < DEPTH_V);
    end
  end

  // Credit counters, occupancy, FIFO pointers, grants and sticky errors.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        crd_q[i]  <= '0;
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
      end
      rxreqlcrdv <= '0;
      rxreq_err  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        crd_q[i] <= crd_n[i] + CNT_W'(grant[i]);
        cnt_q[i] <= cnt_n[i];
        if (write[i]) begin
          wptr_q[i] <= wptr_q[i] + PTR_W'(1);
        end
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + PTR_W'(1);
        end
        if (drop[i]) begin
          rxreq_err[i] <= 1'b1;
        end
        rxreqlcrdv[i] <= grant[i];
      end
    end
  end

  // Flit storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (write[i]) begin
        mem_q[i][wptr_q[i]] <= rxreqflit[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // Advance round-robin on a handshake; hold the grant across a stall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr  <= '0;
      lock_v  <= 1'b0;
      lock_ch <= '0;
    end else begin
      if (handshake) begin
        rr_ptr <= (win == LAST_CH) ? '0 : win + CH_W'(1);
      end
      if (pocq_req_valid && !pocq_req_ready) begin
        lock_v  <= 1'b1;
        lock_ch <= win;
      end else begin
        lock_v  <= 1'b0;
      end
    end
  end

endmodule
